// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// On-chip stimulus/checker for a cross-coupled NOR SR latch.
// Commands arrive over a valid/ready handshake. Each command can drive an
// S and/or R pulse. The block then waits with S=R=0 and samples the
// latch's Q/Qn through a synchronizer. It compares the sample with the
// state the latch should hold and keeps a saturating count of failures.
//
// Handshake: a command transfers at a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, and it is
// already high in the cycle that done pulses, so back-to-back commands
// need a single IDLE cycle. cmd_op is only looked at on the transfer edge.
//
// The FSM state is exported on dbg_state so that checkers can observe it.

module sr_latch_driver #(
  parameter int PULSE_W     = 4,  // cycles S and/or R are held high per command
  parameter int SETTLE_W    = 3,  // cycles of S=R=0 before sampling
  parameter int SYNC_STAGES = 2   // synchronizer depth on q_in/qn_in
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       s_out,
  output logic       r_out,
  input  logic       q_in,
  input  logic       qn_in,
  output logic       done,
  output logic       result_q,
  output logic       mismatch,
  output logic       invalid,
  output logic [7:0] err_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_RESET  = 2'b01,
    OP_HOLD   = 2'b10,
    OP_FORBID = 2'b11
  } op_t;

  // A single counter times both the pulse and the settle phase.
  localparam int CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_W - 1);

  // FSM and command state
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Latch drive
  logic s_q, s_d;
  logic r_q, r_d;

  // Result reporting
  logic       done_q, done_d;
  logic       res_q, res_d;
  logic       mm_q, mm_d;
  logic       inv_q, inv_d;
  logic [7:0] err_q, err_d;

  // Expected latch state, known only after a SET or RESET
  logic exp_valid_q, exp_valid_d;
  logic exp_bit_q, exp_bit_d;

  // Synchronizer chains for the asynchronous latch outputs
  logic [SYNC_STAGES-1:0] q_sync_q;
  logic [SYNC_STAGES-1:0] qn_sync_q;
  logic                   q_s;
  logic                   qn_s;

  // Evaluation of the synchronized sample against the expectation
  logic smp_mm;
  logic smp_inv;
  logic smp_exp_valid;
  logic smp_exp_bit;

  assign q_s  = q_sync_q[SYNC_STAGES-1];
  assign qn_s = qn_sync_q[SYNC_STAGES-1];

  // Shift the latch outputs into the clock domain; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sync_q  <= '0;
      qn_sync_q <= '0;
    end else begin
      q_sync_q  <= {q_sync_q[SYNC_STAGES-2:0], q_in};
      qn_sync_q <= {qn_sync_q[SYNC_STAGES-2:0], qn_in};
    end
  end

  // Judge the current synchronized sample for the command in flight.
  always_comb begin
    smp_inv       = (q_s == qn_s);
    smp_mm        = 1'b0;
    smp_exp_valid = exp_valid_q;
    smp_exp_bit   = exp_bit_q;
    case (op_q)
      OP_SET: begin
        smp_mm        = (q_s != 1'b1) || (qn_s != 1'b0);
        smp_exp_valid = 1'b1;
        smp_exp_bit   = 1'b1;
      end
      OP_RESET: begin
        smp_mm        = (q_s != 1'b0) || (qn_s != 1'b1);
        smp_exp_valid = 1'b1;
        smp_exp_bit   = 1'b0;
      end
      OP_HOLD: begin
        // Without a prior SET/RESET nothing is known, so nothing can mismatch.
        if (exp_valid_q) begin
          smp_mm = (q_s != exp_bit_q) || (qn_s != ~exp_bit_q);
        end
      end
      OP_FORBID: begin
        // Releasing S and R together leaves the latch in an unknown state.
        smp_mm        = 1'b0;
        smp_exp_valid = 1'b0;
      end
      default: begin
        smp_mm = 1'b0;
      end
    endcase
  end

  // Next-state and datapath updates for the command sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    r_d         = r_q;
    done_d      = 1'b0;
    res_d       = res_q;
    mm_d        = mm_q;
    inv_d       = inv_q;
    err_d       = err_q;
    exp_valid_d = exp_valid_q;
    exp_bit_d   = exp_bit_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_t'(cmd_op);
          cnt_d = '0;
          if (op_t'(cmd_op) == OP_HOLD) begin
            // HOLD skips the pulse and only observes the latch.
            state_d = ST_SETTLE;
            s_d     = 1'b0;
            r_d     = 1'b0;
          end else begin
            state_d = ST_DRIVE;
            s_d     = (op_t'(cmd_op) == OP_SET)   || (op_t'(cmd_op) == OP_FORBID);
            r_d     = (op_t'(cmd_op) == OP_RESET) || (op_t'(cmd_op) == OP_FORBID);
          end
        end
      end

      ST_DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          s_d     = 1'b0;
          r_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        state_d     = ST_IDLE;
        done_d      = 1'b1;
        res_d       = q_s;
        mm_d        = smp_mm;
        inv_d       = smp_inv;
        exp_valid_d = smp_exp_valid;
        exp_bit_d   = smp_exp_bit;
        if ((smp_mm || smp_inv) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  // Register all sequencer state; reset wins and drops S/R immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SET;
      cnt_q       <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      done_q      <= 1'b0;
      res_q       <= 1'b0;
      mm_q        <= 1'b0;
      inv_q       <= 1'b0;
      err_q       <= 8'd0;
      exp_valid_q <= 1'b0;
      exp_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      done_q      <= done_d;
      res_q       <= res_d;
      mm_q        <= mm_d;
      inv_q       <= inv_d;
      err_q       <= err_d;
      exp_valid_q <= exp_valid_d;
      exp_bit_q   <= exp_bit_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign done      = done_q;
  assign result_q  = res_q;
  assign mismatch  = mm_q;
  assign invalid   = inv_q;
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver with a behavioural NOR latch attached.
// The latch outputs can be overridden to emulate a faulty latch.
module tb_sr_latch_driver;

  localparam int PULSE_W     = 4;
  localparam int SETTLE_W    = 3;
  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_HOLD   = 2'b10;
  localparam logic [1:0] OP_FORBID = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       s_out, r_out;
  logic       q_in, qn_in;
  logic       done, result_q, mismatch, invalid;
  logic [7:0] err_count;
  logic [1:0] dbg_state;

  // Behavioural latch and override controls
  logic lat_q = 1'b0;
  logic lat_qn = 1'b1;
  logic ovr_en = 1'b0;
  logic ovr_q = 1'b0;
  logic ovr_qn = 1'b0;
  logic forbid_pick = 1'b0;

  assign q_in  = ovr_en ? ovr_q  : lat_q;
  assign qn_in = ovr_en ? ovr_qn : lat_qn;

  // Counters and reference-model state
  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];
  bit m_known = 1'b0;
  bit m_q = 1'b0;
  int m_err = 0;

  typedef struct {
    logic [1:0] op;
    bit         oen;
    bit         oq;
    bit         oqn;
    bit         pick;
    bit         res;
    bit         mm;
    bit         inv;
    int         err;
  } vec_t;
  vec_t tbl[14];

  sr_latch_driver #(
    .PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .s_out(s_out), .r_out(r_out), .q_in(q_in), .qn_in(qn_in),
    .done(done), .result_q(result_q), .mismatch(mismatch), .invalid(invalid),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // NOR latch: responds half a cycle after S/R change; a simultaneous
  // release from S=R=1 resolves to the bench-chosen forbid_pick.
  always @(negedge clk) begin
    if (s_out && r_out) begin
      lat_q = 1'b0; lat_qn = 1'b0;
    end else if (s_out) begin
      lat_q = 1'b1; lat_qn = 1'b0;
    end else if (r_out) begin
      lat_q = 1'b0; lat_qn = 1'b1;
    end else if (!lat_q && !lat_qn) begin
      lat_q = forbid_pick; lat_qn = ~forbid_pick;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got running, required finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts what the checker should report for a command,
  // from the value the latch will present and the rules for each op.
  task automatic model_push(input logic [1:0] op);
    bit sq, sqn, mm, inv;
    if (ovr_en) begin
      sq = ovr_q; sqn = ovr_qn;
    end else begin
      case (op)
        OP_SET:    begin sq = 1'b1; sqn = 1'b0; end
        OP_RESET:  begin sq = 1'b0; sqn = 1'b1; end
        OP_FORBID: begin sq = forbid_pick; sqn = ~forbid_pick; end
        default:   begin sq = lat_q; sqn = lat_qn; end
      endcase
    end
    inv = (sq == sqn);
    case (op)
      OP_SET:   mm = !(sq == 1'b1 && sqn == 1'b0);
      OP_RESET: mm = !(sq == 1'b0 && sqn == 1'b1);
      OP_HOLD:  mm = m_known && !(sq == m_q && sqn == !m_q);
      default:  mm = 1'b0;
    endcase
    case (op)
      OP_SET:    begin m_known = 1'b1; m_q = 1'b1; end
      OP_RESET:  begin m_known = 1'b1; m_q = 1'b0; end
      OP_FORBID: m_known = 1'b0;
      default:   ;
    endcase
    if ((mm || inv) && m_err < 255) m_err++;
    exp_q.push_back({sq, mm, inv, m_err[7:0]});
  endtask

  // Driver: issue one command from IDLE, watch pulses and latency, score result.
  // On return the bench sits #1 after the done edge; cmd_valid/cmd_op are
  // left as chain/next_op so a follow-on command can transfer at the next edge.
  task automatic do_cmd(input logic [1:0] op, input bit chain, input logic [1:0] next_op);
    int waits, lat, s_cnt, r_cnt, exp_lat;
    bit pre, got;
    logic [10:0] exp_v;
    waits = 0; got = 1'b0;
    cmd_valid = 1'b1; cmd_op = op;
    while (!got && waits < 20) begin
      pre = cmd_ready;
      @(posedge clk); #1;
      if (pre) got = 1'b1; else waits++;
    end
    chk("accept_wait", waits, 0);
    if (!got) begin
      cmd_valid = 1'b0;
      return;
    end
    model_push(op);
    chk("busy_after_accept", cmd_ready, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    s_cnt = s_out; r_cnt = r_out; lat = 0;
    cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom_range(0, 3));
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!done) begin
        s_cnt += s_out; r_cnt += r_out;
        cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom_range(0, 3));
      end
    end
    cmd_valid = chain; cmd_op = next_op;
    exp_lat = (op == OP_HOLD) ? SETTLE_W + 1 : PULSE_W + SETTLE_W + 1;
    chk("done_seen", done, 1'b1);
    chk("latency", lat, exp_lat);
    chk("s_pulse_cycles", s_cnt, (op == OP_SET || op == OP_FORBID) ? PULSE_W : 0);
    chk("r_pulse_cycles", r_cnt, (op == OP_RESET || op == OP_FORBID) ? PULSE_W : 0);
    chk("ready_with_done", cmd_ready, 1'b1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("result_tuple", {result_q, mismatch, invalid, err_count}, exp_v);
    end
  endtask

  task automatic set_ovr(input bit en, input bit q, input bit qn);
    ovr_en = en; ovr_q = q; ovr_qn = qn;
  endtask

  initial begin
    bit saw_done;

    //         op         oen oq oqn pick res mm inv err
    tbl[0]  = '{OP_HOLD,   0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{OP_SET,    0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{OP_HOLD,   0, 0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{OP_HOLD,   1, 0, 1, 0, 0, 1, 0, 1};
    tbl[4]  = '{OP_RESET,  0, 0, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{OP_FORBID, 1, 0, 0, 0, 0, 0, 1, 2};
    tbl[6]  = '{OP_HOLD,   1, 1, 0, 0, 1, 0, 0, 2};
    tbl[7]  = '{OP_SET,    1, 1, 1, 0, 1, 1, 1, 3};
    tbl[8]  = '{OP_SET,    0, 0, 0, 0, 1, 0, 0, 3};
    tbl[9]  = '{OP_HOLD,   1, 0, 1, 0, 0, 1, 0, 4};
    tbl[10] = '{OP_RESET,  1, 1, 0, 0, 1, 1, 0, 5};
    tbl[11] = '{OP_HOLD,   1, 0, 0, 0, 0, 1, 1, 6};
    tbl[12] = '{OP_FORBID, 0, 0, 0, 1, 1, 0, 0, 6};
    tbl[13] = '{OP_HOLD,   0, 0, 0, 0, 1, 0, 0, 6};

    // Reset for two edges, then check the idle state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_s", s_out, 1'b0);
    chk("rst_r", r_out, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_outputs", {result_q, mismatch, invalid}, 3'b000);
    chk("rst_err", err_count, 8'd0);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      set_ovr(tbl[i].oen, tbl[i].oq, tbl[i].oqn);
      forbid_pick = tbl[i].pick;
      do_cmd(tbl[i].op, 1'b0, 2'b00);
      chk($sformatf("vec%0d_result", i), result_q, tbl[i].res);
      chk($sformatf("vec%0d_mismatch", i), mismatch, tbl[i].mm);
      chk($sformatf("vec%0d_invalid", i), invalid, tbl[i].inv);
      chk($sformatf("vec%0d_err", i), err_count, tbl[i].err);
    end

    // Back-to-back SET then RESET with cmd_valid held through done.
    set_ovr(1'b0, 1'b0, 1'b0);
    do_cmd(OP_SET, 1'b1, OP_RESET);
    do_cmd(OP_RESET, 1'b0, 2'b00);
    chk("b2b_result", result_q, 1'b0);
    chk("b2b_mismatch", mismatch, 1'b0);

    // Reported flags stay put between commands.
    set_ovr(1'b1, 1'b1, 1'b1);
    do_cmd(OP_SET, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_flags", {done, result_q, mismatch, invalid}, 4'b0111);

    // Randomized commands against the reference model.
    for (int n = 0; n < 200; n++) begin
      set_ovr(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      forbid_pick = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_cmd(2'($urandom_range(0, 3)), 1'b0, 2'b00);
    end

    // Reset in the second DRIVE cycle of a SET.
    set_ovr(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_SET;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rst_mid_s_first", s_out, 1'b1);
    @(posedge clk); #1;
    chk("rst_mid_s_second", s_out, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_s_drop", s_out, 1'b0);
    chk("rst_mid_ready", cmd_ready, 1'b1);
    chk("rst_mid_err", err_count, 8'd0);
    m_known = 1'b0; m_err = 0; exp_q.delete();
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("rst_mid_no_done", saw_done, 1'b0);

    // Stuck-wrong latch: error count saturates at 255.
    set_ovr(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 300; n++) begin
      do_cmd(OP_SET, 1'b0, 2'b00);
    end
    chk("err_saturated", err_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Synchronous exerciser for the cross-coupled NOR SR latch.
- Accepts set/reset/hold/forbidden commands over a valid/ready handshake and drives S and R pulses of programmable width.
- After the pulse it waits, then samples the latch's Q/Qn back through a synchronizer and checks them against the expected state.
- Reports per-command results and keeps a saturating error count.
- Sits between the tile's input pins and the latch, as the on-chip stimulus/checker for it.

Parameters:
PULSE_W, 4, cycles S and/or R are held high per command (>=1)
SETTLE_W, 3, cycles with S=R=0 between pulse release and sampling (>= SYNC_STAGES+1)
SYNC_STAGES, 2, flop stages on q_in/qn_in (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  2  00=SET, 01=RESET, 10=HOLD (no pulse, sample only), 11=FORBID (S and R together)
s_out  output  1  S drive to latch (registered)
r_out  output  1  R drive to latch (registered)
q_in  input  1  latch Q, asynchronous
qn_in  input  1  latch Qn, asynchronous
done  output  1  one-cycle pulse when a command completes
result_q  output  1  synchronized Q captured at sample
mismatch  output  1  sampled Q/Qn differ from expected (valid with done, held until next done)
invalid  output  1  sampled Q == Qn (valid with done, held until next done)
err_count  output  8  count of commands with mismatch or invalid, saturates at 255

Behaviour:
- Reset (rst high at a clk edge): state IDLE; s_out=r_out=0; done=0; result_q=0; mismatch=0; invalid=0; err_count=0; exp_valid=0; exp_q=0; synchronizer flops=0. Takes priority over everything, including an in-flight command: S/R drop at that same edge.
- FSM states IDLE, DRIVE, SETTLE, SAMPLE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid at an edge: latch cmd_op, load counter.
  - SET/RESET/FORBID: go to DRIVE, set s_out/r_out at that edge (SET: s=1; RESET: r=1; FORBID: s=r=1).
  - HOLD: go to SETTLE with s=r=0.
- DRIVE: hold S/R for exactly PULSE_W cycles. Then clear both and go to SETTLE.
- SETTLE: S=R=0 for exactly SETTLE_W cycles, then go to SAMPLE.
- SAMPLE (one cycle): use the synchronized q_s/qn_s. At the edge leaving SAMPLE:
  - result_q=q_s.
  - invalid=(q_s==qn_s).
  - mismatch per op:
    - SET: expect q=1, qn=0; mismatch if q_s!=1 or qn_s!=0; then exp_q=1, exp_valid=1.
    - RESET: expect q=0, qn=1; mismatch if q_s!=0 or qn_s!=1; then exp_q=0, exp_valid=1.
    - HOLD: if exp_valid, mismatch if q_s!=exp_q or qn_s!=~exp_q; else mismatch=0. Expected state unchanged.
    - FORBID: mismatch=0; exp_valid cleared (post-release state is indeterminate). invalid is still evaluated.
  - err_count += 1 if (mismatch|invalid), saturating at 255.
  - done=1 for that one cycle; return to IDLE.
- Latency: accept edge to done-high edge = PULSE_W+SETTLE_W+1 cycles for SET/RESET/FORBID, and SETTLE_W+1 for HOLD.
- Back-to-back: cmd_ready is high again in the cycle done is high, so a new command can be accepted at the next edge. The minimum gap is one IDLE cycle.
- cmd_op is ignored while cmd_ready=0 and need not be held stable after acceptance.
- S and R are never asserted outside DRIVE. S and R are both high only for FORBID.

Test Plan:
- Defaults, behavioural NOR latch attached. rst 2 cycles, then SET → s_out high exactly 4 cycles; done 8 cycles after accept; result_q=1, mismatch=0, invalid=0, err_count=0.
- SET then RESET back-to-back (cmd_valid held) → second accept one cycle after the first done; r_out high 4 cycles; result_q=0, mismatch=0.
- HOLD right after reset → done 4 cycles after accept, s/r stay 0, mismatch=0. HOLD after SET → result_q=1, mismatch=0. Then force q_in=0, qn_in=1 and issue HOLD → mismatch=1, err_count=1.
- FORBID → s_out=r_out=1 for 4 cycles. Then tie q_in=qn_in=0 → invalid=1, mismatch=0, err_count increments. A following HOLD → mismatch=0 (exp_valid cleared).
- Assert rst in the 2nd DRIVE cycle of a SET → s_out=0 and cmd_ready=1 after that edge, no done, err_count=0.
- Drive stuck-wrong latch (q_in=qn_in=1) for 300 SET commands → err_count stops at 255 and does not wrap.
